// File: rtl/dm_bridge_pkg.sv
// dm_bridge_pkg: opcodes, FSM encoding and decode helpers shared by the
// data-memory bridge and its lane aligner.
package dm_bridge_pkg;

    typedef logic [5:0] op_t;

    localparam op_t OP_LB  = 6'b100000;
    localparam op_t OP_LH  = 6'b100001;
    localparam op_t OP_LW  = 6'b100011;
    localparam op_t OP_LBU = 6'b100100;
    localparam op_t OP_LHU = 6'b100101;
    localparam op_t OP_SB  = 6'b101000;
    localparam op_t OP_SH  = 6'b101001;
    localparam op_t OP_SW  = 6'b101011;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int TIMEOUT_DEF = 255;

    function automatic logic is_load(input op_t op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input op_t op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic misaligned(input op_t op, input logic [1:0] a);
        return ((op inside {OP_LH, OP_LHU, OP_SH}) && a[0]) ||
               ((op inside {OP_LW, OP_SW}) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/dm_walign.sv
// dm_walign: byte enables and lane-replicated store data for one access.
module dm_walign
    import dm_bridge_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    always_comb begin
        be_o    = (op_i == OP_SB) ? 4'b0001 << addr_i :
                  (op_i == OP_SH) ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_o = (op_i == OP_SB) ? {4{wdata_i[7:0]}} :
                  (op_i == OP_SH) ? {2{wdata_i[15:0]}} : wdata_i;
    end

endmodule

// File: rtl/dm_bridge.sv
// dm_bridge: stalls the M stage while one load/store runs on a req/ack bus,
// with alignment exceptions and a bounded wait that ends in a bus error.
module dm_bridge
    import dm_bridge_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Valid_M,
    input  logic [5:0]  Op,
    input  logic [31:0] ALU_Out_M,
    input  logic [31:0] WData_M,
    output logic        Stall_M,
    output logic [31:0] DM_Out,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [29:0] Mem_Addr,
    output logic [3:0]  Mem_Be,
    output logic [31:0] Mem_WData,
    input  logic [31:0] Mem_RData,
    input  logic        Mem_Ack,
    output logic        AdEL,
    output logic        AdES,
    output logic        Bus_Err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [29:0]   addr_q;
    logic          we_q, berr_q;
    logic [3:0]    be_q, be_w;
    logic [31:0]   wdata_q, wdata_w, dm_q;
    logic          idle, in_req, ld, st, mis, accept, timeout;

    dm_walign u_walign (
        .op_i    (Op),
        .addr_i  (ALU_Out_M[1:0]),
        .wdata_i (WData_M),
        .be_o    (be_w),
        .wdata_o (wdata_w)
    );

    // Exceptions are only raised while idle; a held instruction in REQ/DONE is ignored.
    always_comb begin
        idle    = st_q == ST_IDLE;
        in_req  = st_q == ST_REQ;
        ld      = is_load(Op);
        st      = is_store(Op);
        mis     = misaligned(Op, ALU_Out_M[1:0]);
        accept  = idle && Valid_M && (ld || st) && !mis;
        timeout = in_req && !Mem_Ack && (cnt_q == CW'(TIMEOUT - 1));
        st_d    = idle   ? (accept ? ST_REQ : ST_IDLE) :
                  in_req ? ((Mem_Ack || timeout) ? ST_DONE : ST_REQ) : ST_IDLE;
        cnt_d   = (in_req && st_d == ST_REQ) ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q    <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            dm_q    <= '0;
            berr_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            berr_q <= timeout;
            if (accept) begin
                addr_q  <= ALU_Out_M[31:2];
                we_q    <= st;
                be_q    <= be_w;
                wdata_q <= wdata_w;
            end
            if (in_req && Mem_Ack && !we_q)
                dm_q <= Mem_RData;
        end
    end

    assign Stall_M   = accept || in_req;
    assign Mem_Req   = in_req;
    assign Mem_We    = we_q;
    assign Mem_Addr  = addr_q;
    assign Mem_Be    = be_q;
    assign Mem_WData = wdata_q;
    assign DM_Out    = dm_q;
    assign Bus_Err   = berr_q;
    assign AdEL      = idle && Valid_M && ld && mis;
    assign AdES      = idle && Valid_M && st && mis;

endmodule

// File: tb/tb_dm_bridge.sv
// tb_dm_bridge: directed and randomized accesses against a per-transaction
// reference model of the bridge's bus and pipeline behaviour.
module tb_dm_bridge;

    localparam int TO = 4;

    logic        clk = 1'b0, reset = 1'b1, Valid_M = 1'b0, Mem_Ack = 1'b0;
    logic [5:0]  Op = '0;
    logic [31:0] ALU_Out_M = '0, WData_M = '0, Mem_RData = '0;
    logic        Stall_M, Mem_Req, Mem_We, AdEL, AdES, Bus_Err;
    logic [31:0] DM_Out, Mem_WData;
    logic [29:0] Mem_Addr;
    logic [3:0]  Mem_Be;

    int          checks = 0, errors = 0;
    logic [31:0] exp_dm = '0;

    always #5 clk = ~clk;

    dm_bridge #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .Valid_M(Valid_M), .Op(Op),
        .ALU_Out_M(ALU_Out_M), .WData_M(WData_M), .Stall_M(Stall_M),
        .DM_Out(DM_Out), .Mem_Req(Mem_Req), .Mem_We(Mem_We),
        .Mem_Addr(Mem_Addr), .Mem_Be(Mem_Be), .Mem_WData(Mem_WData),
        .Mem_RData(Mem_RData), .Mem_Ack(Mem_Ack), .AdEL(AdEL),
        .AdES(AdES), .Bus_Err(Bus_Err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int op_size(input logic [5:0] op);
        case (op)
            6'b100000, 6'b100100, 6'b101000: return 1;
            6'b100001, 6'b100101, 6'b101001: return 2;
            6'b100011, 6'b101011:            return 4;
            default:                         return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [5:0] op);
        return op == 6'b101000 || op == 6'b101001 || op == 6'b101011;
    endfunction

    // ack_at: REQ cycle (0-based) carrying Mem_Ack; ack_at >= TO means never acked.
    task automatic access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] w,
                          input int ack_at, input logic [31:0] rd);
        int          sz;
        bit          st, mis;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        sz  = op_size(op);
        st  = op_store(op);
        mis = sz != 0 && (a % sz) != 0;
        Valid_M = 1'b1; Op = op; ALU_Out_M = a; WData_M = w;
        #1;
        chk("adel", AdEL, sz != 0 && !st && mis);
        chk("ades", AdES, st && mis);
        chk("stall_accept", Stall_M, sz != 0 && !mis);
        chk("req_accept", Mem_Req, 0);
        if (sz == 0 || mis) begin
            step();
            Valid_M = 1'b0;
            chk("req_noaccess", Mem_Req, 0);
            chk("stall_noaccess", Stall_M, 0);
            return;
        end
        ebe = 4'hF;
        ewd = w;
        if (st && sz == 1) begin
            ebe = 4'(1 << (a % 4));
            ewd = {24'b0, w[7:0]} * 32'h0101_0101;
        end else if (st && sz == 2) begin
            ebe = 4'(3 << (a % 4));
            ewd = {16'b0, w[15:0]} * 32'h0001_0001;
        end
        step();
        for (int k = 0; k < TO; k++) begin
            Valid_M = 1'($urandom_range(0, 1)); Op = 6'($urandom); ALU_Out_M = $urandom;
            #1;
            chk("mem_req", Mem_Req, 1);
            chk("stall_req", Stall_M, 1);
            chk("we", Mem_We, st);
            chk("addr", Mem_Addr, a >> 2);
            chk("be", Mem_Be, ebe);
            if (st) chk("wdata", Mem_WData, ewd);
            chk("berr_req", Bus_Err, 0);
            if (k == ack_at) begin Mem_Ack = 1'b1; Mem_RData = rd; end
            step();
            Mem_Ack = 1'b0; Mem_RData = $urandom;
            if (k == ack_at) break;
        end
        if (ack_at < TO && !st) exp_dm = rd;
        chk("req_done", Mem_Req, 0);
        chk("stall_done", Stall_M, 0);
        chk("berr", Bus_Err, ack_at >= TO);
        chk("dm_out", DM_Out, exp_dm);
        Valid_M = 1'b0;
        step();
        chk("berr_clear", Bus_Err, 0);
        chk("req_idle", Mem_Req, 0);
        chk("dm_hold", DM_Out, exp_dm);
    endtask

    logic [5:0] ops [10] = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
                             6'b101000, 6'b101001, 6'b101011, 6'b000000, 6'b100010};

    initial begin
        #3 reset = 1'b0;
        #1;
        chk("rst_req", Mem_Req, 0);
        chk("rst_we", Mem_We, 0);
        chk("rst_berr", Bus_Err, 0);
        chk("rst_addr", Mem_Addr, 0);
        chk("rst_be", Mem_Be, 0);
        chk("rst_wdata", Mem_WData, 0);
        chk("rst_dm", DM_Out, 0);
        chk("rst_stall", Stall_M, 0);
        step();
        step();
        reset = 1'b1;

        access(6'b100011, 32'h0000_0010, 32'h0, 2, 32'hDEAD_BEEF);

        Mem_Ack = 1'b1; Mem_RData = 32'h1111_2222;
        step();
        Mem_Ack = 1'b0;
        chk("ack_outside_dm", DM_Out, exp_dm);
        chk("ack_outside_req", Mem_Req, 0);

        access(6'b101000, 32'h1000_0003, 32'h1234_5678, 1, 32'h0);
        access(6'b101001, 32'h1000_0002, 32'h0000_ABCD, 0, 32'h0);
        access(6'b100011, 32'h1000_0001, 32'h0, 0, 32'h0);
        access(6'b101001, 32'h1000_0001, 32'h5555_6666, 0, 32'h0);
        access(6'b100011, 32'h2000_0008, 32'h0, TO, 32'hBAD0_BAD0);
        access(6'b100101, 32'h2000_0006, 32'h0, TO - 1, 32'hCAFE_F00D);
        access(6'b101011, 32'h2000_000C, 32'hA5A5_5A5A, TO, 32'h0);
        access(6'b000000, 32'h0000_0000, 32'h0, 0, 32'h0);

        Valid_M = 1'b1; Op = 6'b100011; ALU_Out_M = 32'h0000_0020;
        step();
        Valid_M = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        exp_dm = '0;
        chk("midrst_req", Mem_Req, 0);
        chk("midrst_dm", DM_Out, exp_dm);
        chk("midrst_stall", Stall_M, 0);
        chk("midrst_berr", Bus_Err, 0);
        step();
        reset = 1'b1;
        access(6'b100011, 32'h0000_0024, 32'h0, 1, 32'h0BAD_CAFE);

        for (int n = 0; n < 60; n++)
            access(ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom_range(0, TO), $urandom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_bridge.md
DM_BRIDGE -- requirements
Module: dm_bridge

Interface
REQ-001 Parameters: TIMEOUT, default 255, max cycles waited for Mem_Ack before abort.
REQ-002 Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; low forces reset state immediately.
- Valid_M  in  1  M-stage holds a live instruction.
- Op  in  6  M-stage opcode (Instr[31:26]).
- ALU_Out_M  in  32  effective byte address.
- WData_M  in  32  store source (rt value).
- Stall_M  out  1  freeze pipeline at M and earlier.
- DM_Out  out  32  raw read word for the downstream load extender.
- Mem_Req  out  1  bus request.
- Mem_We  out  1  bus write.
- Mem_Addr  out  30  word address.
- Mem_Be  out  4  byte enables.
- Mem_WData  out  32  lane-aligned store data.
- Mem_RData  in  32  bus read data, valid with Mem_Ack.
- Mem_Ack  in  1  single-cycle completion strobe.
- AdEL  out  1  load address error.
- AdES  out  1  store address error.
- Bus_Err  out  1  one-cycle timeout pulse.

Function
REQ-003 Memory ops: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011; all other Op values are non-memory.
REQ-004 Accept condition: Valid_M, memory op, FSM in IDLE, address aligned.
REQ-005 Alignment rules:
- LH/LHU/SH need ALU_Out_M[0]=0.
- LW/SW need ALU_Out_M[1:0]=00.
- Byte ops are always aligned.
REQ-006 Misaligned valid load drives AdEL=1 combinationally in the same cycle; no request, no stall.
REQ-007 Misaligned valid store drives AdES=1 combinationally in the same cycle; no request, no stall.
REQ-008 FSM states: IDLE, REQ, DONE.
- IDLE to REQ on accept.
- REQ to DONE on Mem_Ack or timeout.
- DONE to IDLE unconditionally.
REQ-009 On accept, register the following and hold them stable throughout REQ:
- Mem_Addr = ALU_Out_M[31:2].
- Mem_We = store.
- Mem_Be.
- Mem_WData.
REQ-010 Mem_Req is 1 exactly while in REQ; latency from accept to first Mem_Req is 1 cycle.
REQ-011 Store enables:
- SB: Mem_Be = 0001 shifted left by ALU_Out_M[1:0].
- SH: Mem_Be = 0011 if ALU_Out_M[1]=0, else 1100.
- SW: Mem_Be = 1111.
REQ-012 Load enables: all loads use Mem_Be=1111.
REQ-013 Mem_WData:
- SB: {4{WData_M[7:0]}}.
- SH: {2{WData_M[15:0]}}.
- SW: WData_M.
REQ-014 Stall_M = (IDLE and accept) or REQ; Stall_M is 0 in DONE, so the instruction leaves M exactly once.
REQ-015 Mem_Ack with a load in REQ: capture Mem_RData into DM_Out; DM_Out otherwise holds its value.
REQ-016 Mem_Ack with a store in REQ: DM_Out unchanged.
REQ-017 Mem_Ack outside REQ is ignored.
REQ-018 Wait counter:
- Clears on entry to REQ.
- Increments each REQ cycle without Mem_Ack.
- Reaching TIMEOUT: leave REQ, pulse Bus_Err for 1 cycle, leave DM_Out unchanged.
REQ-019 Mem_Ack on the same cycle the counter reaches TIMEOUT counts as success; no Bus_Err.
REQ-020 Valid_M or Op changes while in REQ or DONE have no effect.
REQ-021 A memory op presented in DONE is not accepted; it is evaluated next cycle in IDLE.

Reset
REQ-022 Reset low asynchronously forces:
- FSM = IDLE, counter = 0.
- Mem_Req, Mem_We, Bus_Err = 0.
- Mem_Addr, Mem_Be, Mem_WData, DM_Out = 0.
REQ-023 Reset during REQ drops Mem_Req immediately and discards the access; no Bus_Err.
REQ-024 The first accept is possible on the first rising edge after reset goes high.

Structure
REQ-025 Shared package holds the opcode constants, the state encoding and the TIMEOUT default.
REQ-026 One combinational sub-module, dm_walign: (Op, ALU_Out_M[1:0], WData_M) -> (Mem_Be, Mem_WData).
REQ-027 FSM, counter and capture register live in dm_bridge.

Verification
REQ-028 Load word:
- Stimulus: LW, addr 0x0000_0010, Mem_Ack 3 cycles after Mem_Req with RData 0xDEADBEEF.
- Response: Mem_Addr=0x4, Be=1111, Stall_M high 4 cycles, DM_Out=0xDEADBEEF.
REQ-029 Store byte:
- Stimulus: SB, addr 0x...3, WData 0x12345678.
- Response: Be=1000, Mem_WData=0x78787878, We=1.
REQ-030 Store halfword:
- Stimulus: SH, addr 0x...2, WData 0x0000ABCD.
- Response: Be=1100, Mem_WData=0xABCDABCD.
REQ-031 Misaligned accesses:
- LW at 0x...1: AdEL=1, Mem_Req stays 0, Stall_M=0.
- SH at 0x...1: AdES=1, Mem_Req stays 0, Stall_M=0.
REQ-032 Timeout:
- Stimulus: no Mem_Ack, TIMEOUT=4.
- Response: Mem_Req high 4 cycles, Bus_Err one pulse, return to IDLE, DM_Out unchanged.
REQ-033 Reset mid-access:
- Stimulus: reset low 2 cycles into REQ.
- Response: Mem_Req=0 immediately, DM_Out=0; next LW completes normally.
